// File: rtl/cache_tag_ctrl.sv
// rtl/cache_tag_ctrl.sv - 4-way MOESI tag array sequencing controller (core + snoop, single-way write port)
// Optional counters stat_hits/stat_misses/stat_snp_inval when CACHE_TAG_CTRL_STATS_EN is defined.
module cache_tag_ctrl #(
   parameter int SETS       = 128,
   parameter int WAYS       = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int TAG_WIDTH  = ADDR_WIDTH - $clog2(SETS) - 6,
   parameter int LRU_BITS   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      core_req_valid,
   output logic                      core_req_ready,
   input  logic [1:0]                core_req_op,
   input  logic [ADDR_WIDTH-1:0]     core_req_addr,
   input  logic [2:0]                core_req_state,
   input  logic                      snp_req_valid,
   output logic                      snp_req_ready,
   input  logic [ADDR_WIDTH-1:0]     snp_req_addr,
   input  logic [2:0]                snp_req_state,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic                      resp_src,
   output logic                      resp_hit,
   output logic [$clog2(WAYS)-1:0]   resp_way,
   output logic [2:0]                resp_old_state,
   output logic [TAG_WIDTH-1:0]      resp_victim_tag,
   output logic [$clog2(SETS)-1:0]   ta_read_set,
   input  logic [WAYS*TAG_WIDTH-1:0] ta_read_tags,
   input  logic [WAYS-1:0]           ta_read_valids,
   input  logic [WAYS*3-1:0]         ta_read_states,
   input  logic [WAYS*LRU_BITS-1:0]  ta_read_lru,
   output logic                      ta_write_en,
   output logic [$clog2(SETS)-1:0]   ta_write_set,
   output logic [$clog2(WAYS)-1:0]   ta_write_way,
   output logic [TAG_WIDTH-1:0]      ta_write_tag,
   output logic                      ta_write_valid,
   output logic [2:0]                ta_write_state,
   output logic [LRU_BITS-1:0]       ta_write_lru,
`ifdef CACHE_TAG_CTRL_STATS_EN
   output logic [31:0]               stat_hits,
   output logic [31:0]               stat_misses,
   output logic [31:0]               stat_snp_inval,
`endif
   output logic                      busy
);
   localparam int SET_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam logic [2:0] ST_I = 3'b000;
   localparam logic [1:0] OP_LOOKUP = 2'b00;
   localparam logic [1:0] OP_FILL   = 2'b01;
   localparam logic [1:0] OP_SET    = 2'b10;
   localparam logic [1:0] OP_RSVD   = 2'b11;
   localparam logic [LRU_BITS-1:0] AGE_MAX = LRU_BITS'(WAYS - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_RESP} state_t;
   state_t state, state_nx;

   logic [1:0]           op_q;
   logic [SET_W-1:0]     set_q;
   logic [TAG_WIDTH-1:0] tag_q;
   logic [2:0]           new_state_q;
   logic                 src_q;
   logic [TAG_WIDTH-1:0] wr_tag_q   [WAYS];
   logic                 wr_valid_q [WAYS];
   logic [2:0]           wr_state_q [WAYS];
   logic [LRU_BITS-1:0]  wr_lru_q   [WAYS];
   logic [WAY_W-1:0]     wr_way_q;
   logic                 wr_single_q;

   logic [TAG_WIDTH-1:0] rd_tag   [WAYS];
   logic [2:0]           rd_state [WAYS];
   logic [LRU_BITS-1:0]  rd_lru   [WAYS];

   for (genvar w = 0; w < WAYS; w++) begin : g_unpack
      assign rd_tag[w]   = ta_read_tags[w*TAG_WIDTH +: TAG_WIDTH];
      assign rd_state[w] = ta_read_states[w*3 +: 3];
      assign rd_lru[w]   = ta_read_lru[w*LRU_BITS +: LRU_BITS];
   end

   logic unused_addr_bits;
   assign unused_addr_bits = ^{core_req_addr[5:0], snp_req_addr[5:0]};
   assign ta_read_set = set_q;

   // Resolution of the snapshot read in LOOKUP: hit, victim, and every way's post-update fields.
   logic                 hit, hit_eff, found_inv, found_old, do_touch, do_set, is_fill, uses_way;
   logic [WAY_W-1:0]     hit_way, inv_way, old_way, victim, target;
   logic [LRU_BITS-1:0]  touch_age;
   logic [TAG_WIDTH-1:0] nx_tag   [WAYS];
   logic                 nx_valid [WAYS];
   logic [2:0]           nx_state [WAYS];
   logic [LRU_BITS-1:0]  nx_lru   [WAYS];

   always_comb begin
      hit = 1'b0;
      hit_way = '0;
      found_inv = 1'b0;
      found_old = 1'b0;
      inv_way = '0;
      old_way = '0;
      // Descending scans so the lowest matching index is the one that sticks.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (ta_read_valids[w] && rd_tag[w] == tag_q) begin
            hit = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!ta_read_valids[w]) begin
            found_inv = 1'b1;
            inv_way = WAY_W'(w);
         end
         if (rd_lru[w] == AGE_MAX) begin
            found_old = 1'b1;
            old_way = WAY_W'(w);
         end
      end
      victim    = found_inv ? inv_way : (found_old ? old_way : '0);
      hit_eff   = hit && (op_q != OP_RSVD);
      is_fill   = (op_q == OP_FILL);
      target    = (is_fill && !hit_eff) ? victim : hit_way;
      touch_age = hit_eff ? rd_lru[hit_way] : AGE_MAX;
      do_touch  = is_fill || (op_q == OP_LOOKUP && hit_eff);
      do_set    = (op_q == OP_SET) && hit_eff;
      uses_way  = is_fill || hit_eff;
      for (int w = 0; w < WAYS; w++) begin
         nx_tag[w]   = rd_tag[w];
         nx_valid[w] = ta_read_valids[w];
         nx_state[w] = rd_state[w];
         nx_lru[w]   = rd_lru[w];
         if (do_touch) begin
            if (WAY_W'(w) == target)
               nx_lru[w] = '0;
            else if (ta_read_valids[w] && rd_lru[w] < touch_age)
               nx_lru[w] = rd_lru[w] + 1'b1;
         end
         if (is_fill && WAY_W'(w) == target) begin
            nx_tag[w]   = tag_q;
            nx_valid[w] = 1'b1;
            nx_state[w] = new_state_q;
         end
         if (do_set && WAY_W'(w) == hit_way) begin
            nx_state[w] = new_state_q;
            nx_valid[w] = (new_state_q != ST_I);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx       = state;
      snp_req_ready  = 1'b0;
      core_req_ready = 1'b0;
      resp_valid     = 1'b0;
      ta_write_en    = 1'b0;
      ta_write_set   = '0;
      ta_write_way   = '0;
      ta_write_tag   = '0;
      ta_write_valid = 1'b0;
      ta_write_state = '0;
      ta_write_lru   = '0;
      busy           = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            snp_req_ready  = !rst;
            core_req_ready = !rst && !snp_req_valid;
            if (snp_req_valid || core_req_valid) state_nx = S_LOOKUP;
         end
         S_LOOKUP: state_nx = (do_touch || do_set) ? S_UPDATE : S_RESP;
         S_UPDATE: begin
            ta_write_en    = 1'b1;
            ta_write_set   = set_q;
            ta_write_way   = wr_way_q;
            ta_write_tag   = wr_tag_q[wr_way_q];
            ta_write_valid = wr_valid_q[wr_way_q];
            ta_write_state = wr_state_q[wr_way_q];
            ta_write_lru   = wr_lru_q[wr_way_q];
            if (wr_single_q || wr_way_q == WAY_W'(WAYS - 1)) state_nx = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= '0; set_q <= '0; tag_q <= '0; new_state_q <= '0; src_q <= 1'b0;
         wr_way_q <= '0; wr_single_q <= 1'b0;
         resp_src <= 1'b0; resp_hit <= 1'b0; resp_way <= '0;
         resp_old_state <= '0; resp_victim_tag <= '0;
         for (int w = 0; w < WAYS; w++) begin
            wr_tag_q[w] <= '0; wr_valid_q[w] <= 1'b0; wr_state_q[w] <= '0; wr_lru_q[w] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (snp_req_valid && snp_req_ready) begin
                  op_q <= OP_SET; src_q <= 1'b1; new_state_q <= snp_req_state;
                  set_q <= snp_req_addr[6 +: SET_W];
                  tag_q <= snp_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
               end else if (core_req_valid && core_req_ready) begin
                  op_q <= core_req_op; src_q <= 1'b0; new_state_q <= core_req_state;
                  set_q <= core_req_addr[6 +: SET_W];
                  tag_q <= core_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
               end
            end
            S_LOOKUP: begin
               resp_src        <= src_q;
               resp_hit        <= hit_eff;
               resp_way        <= uses_way ? target : '0;
               resp_old_state  <= (uses_way && ta_read_valids[target]) ? rd_state[target] : ST_I;
               resp_victim_tag <= uses_way ? rd_tag[target] : '0;
               wr_way_q        <= do_set ? hit_way : '0;
               wr_single_q     <= do_set;
               for (int w = 0; w < WAYS; w++) begin
                  wr_tag_q[w] <= nx_tag[w]; wr_valid_q[w] <= nx_valid[w];
                  wr_state_q[w] <= nx_state[w]; wr_lru_q[w] <= nx_lru[w];
               end
            end
            S_UPDATE: wr_way_q <= wr_way_q + 1'b1;
            default: ;
         endcase
      end
   end

`ifdef CACHE_TAG_CTRL_STATS_EN
   logic cur_hit, resp_entry;
   // From LOOKUP the registered resp_hit is not yet loaded, so use the live result.
   assign cur_hit    = (state == S_LOOKUP) ? hit_eff : resp_hit;
   assign resp_entry = (state != S_RESP) && (state_nx == S_RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_hits <= '0; stat_misses <= '0; stat_snp_inval <= '0;
      end else if (resp_entry) begin
         if (!src_q && (op_q == OP_LOOKUP || op_q == OP_FILL)) begin
            if (cur_hit) stat_hits   <= stat_hits + 32'd1;
            else         stat_misses <= stat_misses + 32'd1;
         end
         if (src_q && op_q == OP_SET && cur_hit && new_state_q == ST_I)
            stat_snp_inval <= stat_snp_inval + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb/tb_cache_tag_ctrl.sv - randomized self-checking bench for cache_tag_ctrl against a behavioural tag-array model
module tb_cache_tag_ctrl;
   localparam int SETS = 128, WAYS = 4, AW = 32, TW = 19, LB = 2;

   logic clk = 1'b0, rst = 1'b1;
   logic core_req_valid = 0, core_req_ready;
   logic [1:0] core_req_op = 0;
   logic [AW-1:0] core_req_addr = 0;
   logic [2:0] core_req_state = 0;
   logic snp_req_valid = 0, snp_req_ready;
   logic [AW-1:0] snp_req_addr = 0;
   logic [2:0] snp_req_state = 0;
   logic resp_valid, resp_ready = 0, resp_src, resp_hit;
   logic [1:0] resp_way;
   logic [2:0] resp_old_state;
   logic [TW-1:0] resp_victim_tag;
   logic [6:0] ta_read_set, ta_write_set;
   logic [WAYS*TW-1:0] ta_read_tags;
   logic [WAYS-1:0] ta_read_valids;
   logic [WAYS*3-1:0] ta_read_states;
   logic [WAYS*LB-1:0] ta_read_lru;
   logic ta_write_en, ta_write_valid, busy;
   logic [1:0] ta_write_way;
   logic [TW-1:0] ta_write_tag;
   logic [2:0] ta_write_state;
   logic [LB-1:0] ta_write_lru;
`ifdef CACHE_TAG_CTRL_STATS_EN
   logic [31:0] stat_hits, stat_misses, stat_snp_inval;
`endif

   int checks = 0, failures = 0;
   int wr_count = 0;

   // Tag array storage the DUT reads and writes.
   logic [TW-1:0] mem_tag [SETS][WAYS];
   logic          mem_val [SETS][WAYS];
   logic [2:0]    mem_st  [SETS][WAYS];
   logic [LB-1:0] mem_lru [SETS][WAYS];

   // Reference model state.
   logic [TW-1:0] r_tag [SETS][WAYS];
   bit            r_val [SETS][WAYS];
   logic [2:0]    r_st  [SETS][WAYS];
   int            r_age [SETS][WAYS];

   cache_tag_ctrl dut (
      .clk(clk), .rst(rst),
      .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_op(core_req_op),
      .core_req_addr(core_req_addr), .core_req_state(core_req_state),
      .snp_req_valid(snp_req_valid), .snp_req_ready(snp_req_ready),
      .snp_req_addr(snp_req_addr), .snp_req_state(snp_req_state),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_src(resp_src), .resp_hit(resp_hit),
      .resp_way(resp_way), .resp_old_state(resp_old_state), .resp_victim_tag(resp_victim_tag),
      .ta_read_set(ta_read_set), .ta_read_tags(ta_read_tags), .ta_read_valids(ta_read_valids),
      .ta_read_states(ta_read_states), .ta_read_lru(ta_read_lru),
      .ta_write_en(ta_write_en), .ta_write_set(ta_write_set), .ta_write_way(ta_write_way),
      .ta_write_tag(ta_write_tag), .ta_write_valid(ta_write_valid), .ta_write_state(ta_write_state),
      .ta_write_lru(ta_write_lru),
`ifdef CACHE_TAG_CTRL_STATS_EN
      .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_snp_inval(stat_snp_inval),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      ta_read_tags = '0; ta_read_valids = '0; ta_read_states = '0; ta_read_lru = '0;
      for (int w = 0; w < WAYS; w++) begin
         ta_read_tags[w*TW +: TW] = mem_tag[ta_read_set][w];
         ta_read_valids[w]        = mem_val[ta_read_set][w];
         ta_read_states[w*3 +: 3] = mem_st[ta_read_set][w];
         ta_read_lru[w*LB +: LB]  = mem_lru[ta_read_set][w];
      end
   end

   always @(posedge clk) begin
      if (ta_write_en) begin
         mem_tag[ta_write_set][ta_write_way] <= ta_write_tag;
         mem_val[ta_write_set][ta_write_way] <= ta_write_valid;
         mem_st[ta_write_set][ta_write_way]  <= ta_write_state;
         mem_lru[ta_write_set][ta_write_way] <= ta_write_lru;
         wr_count <= wr_count + 1;
      end
   end

   function automatic logic [31:0] mk_addr(input int s, input int t);
      return (32'(t) << 13) | (32'(s) << 6) | 32'($urandom_range(0, 63));
   endfunction

   // Behavioural model: predicts the response and applies the first apply_ways way-updates.
   task automatic ref_access(input logic [1:0] op, input logic [31:0] addr, input logic [2:0] st,
                             input int apply_ways, output bit e_hit, output int e_way,
                             output logic [2:0] e_old, output logic [TW-1:0] e_vtag,
                             output int e_lat, output int e_nwr);
      int s, hw, tgt, a;
      logic [TW-1:0] t;
      int inv_q[$], old_q[$];
      bit touch;
      logic [TW-1:0] n_tag [WAYS];
      bit n_val [WAYS];
      logic [2:0] n_st [WAYS];
      int n_age [WAYS];
      s = int'(addr[12:6]);
      t = addr[31:13];
      hw = -1;
      for (int w = 0; w < WAYS; w++) begin
         if (hw < 0 && r_val[s][w] && r_tag[s][w] == t) hw = w;
         if (!r_val[s][w]) inv_q.push_back(w);
         if (r_age[s][w] == WAYS - 1) old_q.push_back(w);
         n_tag[w] = r_tag[s][w]; n_val[w] = r_val[s][w]; n_st[w] = r_st[s][w]; n_age[w] = r_age[s][w];
      end
      e_hit = (hw >= 0) && (op != 2'b11);
      tgt = (hw < 0) ? 0 : hw;
      a = 0; touch = 0; e_lat = 2; e_nwr = 0;
      if (op == 2'b01) begin
         if (!e_hit) tgt = inv_q.size() > 0 ? inv_q[0] : (old_q.size() > 0 ? old_q[0] : 0);
         a = e_hit ? r_age[s][hw] : WAYS - 1;
         touch = 1;
      end else if (op == 2'b00 && e_hit) begin
         a = r_age[s][hw];
         touch = 1;
      end else if (op == 2'b10 && e_hit) begin
         n_st[hw] = st; n_val[hw] = (st != 3'b000);
         e_lat = 3; e_nwr = 1;
      end
      if (touch) begin
         for (int j = 0; j < WAYS; j++)
            if (j == tgt) n_age[j] = 0;
            else if (r_val[s][j] && r_age[s][j] < a) n_age[j] = r_age[s][j] + 1;
         if (op == 2'b01) begin n_tag[tgt] = t; n_val[tgt] = 1; n_st[tgt] = st; end
         e_lat = 2 + WAYS; e_nwr = WAYS;
      end
      e_way  = (op == 2'b01 || e_hit) ? tgt : 0;
      e_old  = ((op == 2'b01 || e_hit) && r_val[s][tgt]) ? r_st[s][tgt] : 3'b000;
      e_vtag = (op == 2'b01 || e_hit) ? r_tag[s][tgt] : '0;
      for (int w = 0; w < WAYS; w++)
         if (w < apply_ways || e_nwr == 1 && apply_ways > 0) begin
            r_tag[s][w] = n_tag[w]; r_val[s][w] = n_val[w]; r_st[s][w] = n_st[w]; r_age[s][w] = n_age[w];
         end
   endtask

   // Issues one request from an idle DUT (called #1 after a posedge) and collects the response.
   task automatic do_req(input bit src, input logic [1:0] op, input logic [31:0] addr, input logic [2:0] st,
                         input int ready_delay, output int lat, output int nwr, output bit timeout);
      int base;
      if (src) begin snp_req_valid = 1; snp_req_addr = addr; snp_req_state = st; end
      else begin core_req_valid = 1; core_req_op = op; core_req_addr = addr; core_req_state = st; end
      base = wr_count;
      @(posedge clk); #1;
      snp_req_valid = 0; core_req_valid = 0;
      lat = 1;
      while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      timeout = !resp_valid;
      nwr = wr_count - base;
      repeat (ready_delay) begin @(posedge clk); #1; end
   endtask

   task automatic ack_resp();
      resp_ready = 1; @(posedge clk); #1; resp_ready = 0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (resp_valid !== 0 || busy !== 0 || ta_write_en !== 0) begin failures++;
         $display("FAIL reset_ctl resp_valid=%0b busy=%0b ta_write_en=%0b required 0/0/0", resp_valid, busy, ta_write_en); end
      checks++; if (snp_req_ready !== 0 || core_req_ready !== 0 || resp_hit !== 0 || ta_read_set !== 0) begin failures++;
         $display("FAIL reset_out snp_rdy=%0b core_rdy=%0b hit=%0b rset=%0d required all 0", snp_req_ready, core_req_ready, resp_hit, ta_read_set); end
      @(posedge clk); #1; rst = 0; #1;
      checks++; if (snp_req_ready !== 1 || core_req_ready !== 1) begin failures++;
         $display("FAIL reset_ready snp=%0b core=%0b required 1/1", snp_req_ready, core_req_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_fill_empty();
      int lat, nwr, e_way, e_lat, e_nwr; bit to, e_hit; logic [2:0] e_old; logic [TW-1:0] e_vtag;
      ref_access(2'b01, 32'h0000_2040, 3'b100, WAYS, e_hit, e_way, e_old, e_vtag, e_lat, e_nwr);
      do_req(0, 2'b01, 32'h0000_2040, 3'b100, 0, lat, nwr, to);
      checks++; if (to || resp_hit !== 0 || resp_way !== 0 || resp_old_state !== 3'b000) begin failures++;
         $display("FAIL fill_empty_resp to=%0b hit=%0b way=%0d old=%0d required 0/0/0/0", to, resp_hit, resp_way, resp_old_state); end
      checks++; if (lat != 6 || nwr != 4) begin failures++;
         $display("FAIL fill_empty_lat lat=%0d nwr=%0d required 6/4", lat, nwr); end
      ack_resp();
      checks++; if (mem_tag[1][0] !== 1 || mem_val[1][0] !== 1 || mem_st[1][0] !== 3'b100 || mem_lru[1][0] !== 0) begin failures++;
         $display("FAIL fill_empty_way0 tag=%0d v=%0b st=%0d lru=%0d required 1/1/4/0", mem_tag[1][0], mem_val[1][0], mem_st[1][0], mem_lru[1][0]); end
   endtask

   task automatic test_fill_set();
      int lat, nwr, e_way, e_lat, e_nwr; bit to, e_hit; logic [2:0] e_old; logic [TW-1:0] e_vtag; logic [31:0] a;
      for (int t = 2; t <= 4; t++) begin
         a = mk_addr(1, t);
         ref_access(2'b01, a, 3'b011, WAYS, e_hit, e_way, e_old, e_vtag, e_lat, e_nwr);
         do_req(0, 2'b01, a, 3'b011, 0, lat, nwr, to);
         checks++; if (to || resp_way !== 2'(t - 1)) begin failures++;
            $display("FAIL fill_set_way tag=%0d way=%0d required %0d", t, resp_way, t - 1); end
         ack_resp();
      end
      a = mk_addr(1, 1);
      ref_access(2'b00, a, 3'b000, WAYS, e_hit, e_way, e_old, e_vtag, e_lat, e_nwr);
      do_req(0, 2'b00, a, 3'b000, 1, lat, nwr, to);
      checks++; if (to || resp_hit !== 1 || resp_way !== 0 || lat != 6) begin failures++;
         $display("FAIL lookup_hit hit=%0b way=%0d lat=%0d required 1/0/6", resp_hit, resp_way, lat); end
      ack_resp();
      checks++; if (mem_lru[1][0] !== 0 || mem_lru[1][1] !== 3 || mem_lru[1][2] !== 2 || mem_lru[1][3] !== 1) begin failures++;
         $display("FAIL lookup_ages %0d %0d %0d %0d required 0 3 2 1", mem_lru[1][0], mem_lru[1][1], mem_lru[1][2], mem_lru[1][3]); end
   endtask

   task automatic test_victim();
      int lat, nwr, e_way, e_lat, e_nwr; bit to, e_hit; logic [2:0] e_old; logic [TW-1:0] e_vtag; logic [31:0] a;
      a = mk_addr(1, 5);
      ref_access(2'b01, a, 3'b001, WAYS, e_hit, e_way, e_old, e_vtag, e_lat, e_nwr);
      do_req(0, 2'b01, a, 3'b001, 0, lat, nwr, to);
      checks++; if (to || resp_hit !== 0 || resp_way !== 1 || resp_victim_tag !== 2) begin failures++;
         $display("FAIL victim_resp hit=%0b way=%0d vtag=%0d required 0/1/2", resp_hit, resp_way, resp_victim_tag); end
      ack_resp();
      checks++; if (mem_tag[1][1] !== 5 || mem_lru[1][1] !== 0 || mem_lru[1][0] !== 1 || mem_lru[1][2] !== 3 || mem_lru[1][3] !== 2) begin failures++;
         $display("FAIL victim_ages tag1=%0d ages %0d %0d %0d %0d required 5, 1 0 3 2", mem_tag[1][1], mem_lru[1][0], mem_lru[1][1], mem_lru[1][2], mem_lru[1][3]); end
   endtask

   task automatic test_snoop_inval();
      int lat, nwr, e_way, e_lat, e_nwr; bit to, e_hit; logic [2:0] e_old; logic [TW-1:0] e_vtag; logic [31:0] a;
      a = mk_addr(1, 5);
      ref_access(2'b10, a, 3'b000, WAYS, e_hit, e_way, e_old, e_vtag, e_lat, e_nwr);
      do_req(1, 2'b10, a, 3'b000, 0, lat, nwr, to);
      checks++; if (to || resp_src !== 1 || resp_hit !== 1 || resp_way !== 1 || resp_old_state !== 3'b001 || lat != 3 || nwr != 1) begin failures++;
         $display("FAIL snp_inval_resp src=%0b hit=%0b way=%0d old=%0d lat=%0d nwr=%0d required 1/1/1/1/3/1", resp_src, resp_hit, resp_way, resp_old_state, lat, nwr); end
      ack_resp();
      checks++; if (mem_val[1][1] !== 0 || mem_lru[1][1] !== 0) begin failures++;
         $display("FAIL snp_inval_way v=%0b lru=%0d required 0/0", mem_val[1][1], mem_lru[1][1]); end
      a = mk_addr(1, 5);
      ref_access(2'b00, a, 3'b000, WAYS, e_hit, e_way, e_old, e_vtag, e_lat, e_nwr);
      do_req(0, 2'b00, a, 3'b000, 0, lat, nwr, to);
      checks++; if (to || resp_hit !== 0 || nwr != 0 || lat != 2) begin failures++;
         $display("FAIL lookup_after_inval hit=%0b nwr=%0d lat=%0d required 0/0/2", resp_hit, nwr, lat); end
      ack_resp();
   endtask

   task automatic test_arbitration();
      int n, e_way, e_lat, e_nwr; bit e_hit, leaked; logic [2:0] e_old; logic [TW-1:0] e_vtag;
      snp_req_valid = 1; snp_req_addr = mk_addr(2, 9); snp_req_state = 3'b011;
      core_req_valid = 1; core_req_op = 2'b00; core_req_addr = mk_addr(2, 9); core_req_state = 0;
      ref_access(2'b10, snp_req_addr, 3'b011, WAYS, e_hit, e_way, e_old, e_vtag, e_lat, e_nwr);
      #1;
      checks++; if (snp_req_ready !== 1 || core_req_ready !== 0) begin failures++;
         $display("FAIL arb_ready snp=%0b core=%0b required 1/0", snp_req_ready, core_req_ready); end
      @(posedge clk); #1; snp_req_valid = 0;
      n = 0; leaked = 0;
      while (!resp_valid && n < 40) begin if (core_req_ready) leaked = 1; @(posedge clk); #1; n++; end
      if (core_req_ready) leaked = 1;
      checks++; if (!resp_valid || resp_src !== 1 || leaked || resp_hit !== e_hit) begin failures++;
         $display("FAIL arb_snoop_first valid=%0b src=%0b core_ready_leak=%0b hit=%0b required 1/1/0/%0b", resp_valid, resp_src, leaked, resp_hit, e_hit); end
      ack_resp();
      checks++; if (core_req_ready !== 1) begin failures++;
         $display("FAIL arb_core_ready core_ready=%0b required 1", core_req_ready); end
      ref_access(2'b00, core_req_addr, 3'b000, WAYS, e_hit, e_way, e_old, e_vtag, e_lat, e_nwr);
      @(posedge clk); #1; core_req_valid = 0;
      n = 1;
      while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
      checks++; if (!resp_valid || resp_src !== 0 || n != e_lat) begin failures++;
         $display("FAIL arb_core_second valid=%0b src=%0b lat=%0d required 1/0/%0d", resp_valid, resp_src, n, e_lat); end
      ack_resp();
   endtask

   task automatic test_reset_mid();
      int n, lat, nwr, e_way, e_lat, e_nwr; bit to, e_hit, seen; logic [2:0] e_old; logic [TW-1:0] e_vtag; logic [31:0] a;
      a = mk_addr(3, 7);
      core_req_valid = 1; core_req_op = 2'b01; core_req_addr = a; core_req_state = 3'b010;
      @(posedge clk); #1; core_req_valid = 0;
      n = 0;
      while (!(ta_write_en && ta_write_way == 2) && n < 20) begin @(posedge clk); #1; n++; end
      checks++; if (!(ta_write_en && ta_write_way == 2)) begin failures++;
         $display("FAIL rst_mid_reach write_en=%0b way=%0d required 1/2", ta_write_en, ta_write_way); end
      rst = 1; #1;
      checks++; if (ta_write_en !== 0 || resp_valid !== 0 || busy !== 0) begin failures++;
         $display("FAIL rst_mid_drop write_en=%0b resp_valid=%0b busy=%0b required 0/0/0", ta_write_en, resp_valid, busy); end
      @(posedge clk); #1; rst = 0;
      seen = 0;
      repeat (4) begin if (resp_valid || busy) seen = 1; @(posedge clk); #1; end
      checks++; if (seen) begin failures++; $display("FAIL rst_mid_noresp spurious activity=%0b required 0", seen); end
      ref_access(2'b01, a, 3'b010, 2, e_hit, e_way, e_old, e_vtag, e_lat, e_nwr);
      for (int w = 0; w < WAYS; w++) begin
         checks++; if (mem_tag[3][w] !== r_tag[3][w] || mem_val[3][w] !== r_val[3][w] || int'(mem_lru[3][w]) != r_age[3][w]) begin failures++;
            $display("FAIL rst_mid_array way=%0d tag=%0d v=%0b lru=%0d required %0d/%0b/%0d", w, mem_tag[3][w], mem_val[3][w], mem_lru[3][w], r_tag[3][w], r_val[3][w], r_age[3][w]); end
      end
      ref_access(2'b00, a, 3'b000, WAYS, e_hit, e_way, e_old, e_vtag, e_lat, e_nwr);
      do_req(0, 2'b00, a, 3'b000, 0, lat, nwr, to);
      checks++; if (to || resp_hit !== e_hit || resp_way !== 2'(e_way) || lat != e_lat) begin failures++;
         $display("FAIL rst_mid_next hit=%0b way=%0d lat=%0d required %0b/%0d/%0d", resp_hit, resp_way, lat, e_hit, e_way, e_lat); end
      ack_resp();
   endtask

   task automatic test_random();
      int lat, nwr, e_way, e_lat, e_nwr, s; bit to, e_hit, src; logic [2:0] e_old, st; logic [TW-1:0] e_vtag;
      logic [1:0] op; logic [31:0] a;
      for (int i = 0; i < 250; i++) begin
         src = ($urandom_range(0, 3) == 0);
         op  = src ? 2'b10 : 2'($urandom_range(0, 3));
         s   = $urandom_range(4, 7);
         a   = mk_addr(s, $urandom_range(1, 6));
         st  = 3'($urandom_range(0, 7));
         ref_access(op, a, st, WAYS, e_hit, e_way, e_old, e_vtag, e_lat, e_nwr);
         do_req(src, op, a, st, $urandom_range(0, 2), lat, nwr, to);
         checks++; if (to || resp_src !== src || resp_hit !== e_hit || resp_way !== 2'(e_way)) begin failures++;
            $display("FAIL rnd_resp i=%0d op=%0d to=%0b src=%0b hit=%0b way=%0d required %0b/%0b/%0d", i, op, to, resp_src, resp_hit, resp_way, src, e_hit, e_way); end
         checks++; if (resp_old_state !== e_old || resp_victim_tag !== e_vtag) begin failures++;
            $display("FAIL rnd_old i=%0d old=%0d vtag=%0d required %0d/%0d", i, resp_old_state, resp_victim_tag, e_old, e_vtag); end
         checks++; if (lat != e_lat || nwr != e_nwr) begin failures++;
            $display("FAIL rnd_timing i=%0d lat=%0d nwr=%0d required %0d/%0d", i, lat, nwr, e_lat, e_nwr); end
         ack_resp();
         for (int w = 0; w < WAYS; w++) begin
            checks++;
            if (mem_val[s][w] !== r_val[s][w] || int'(mem_lru[s][w]) != r_age[s][w] ||
                (r_val[s][w] && (mem_tag[s][w] !== r_tag[s][w] || mem_st[s][w] !== r_st[s][w]))) begin failures++;
               $display("FAIL rnd_array i=%0d set=%0d way=%0d tag=%0d v=%0b st=%0d lru=%0d required %0d/%0b/%0d/%0d", i, s, w,
                        mem_tag[s][w], mem_val[s][w], mem_st[s][w], mem_lru[s][w], r_tag[s][w], r_val[s][w], r_st[s][w], r_age[s][w]); end
         end
      end
   endtask

   initial begin
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            mem_tag[s][w] = '0; mem_val[s][w] = 0; mem_st[s][w] = '0; mem_lru[s][w] = '0;
            r_tag[s][w] = '0; r_val[s][w] = 0; r_st[s][w] = '0; r_age[s][w] = 0;
         end
      test_reset();
      test_fill_empty();
      test_fill_set();
      test_victim();
      test_snoop_inval();
      test_arbitration();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cache_tag_ctrl.md
Name: cache_tag_ctrl

Overview:
- Sequencing controller for the 4-way MOESI tag array. Each core-side L1 cache has one instance.
- Arbitrates between two request sources: the core port (LOOKUP/FILL/SET_STATE) and the snoop port (SET_STATE).
- Reads one set, resolves hit, victim and LRU, then writes the updated ways back through the single-way write port, one way per cycle.
- Processes one request at a time, so snapshot-versus-write hazards cannot occur.

Parameters:
- SETS, 128, number of sets.
- WAYS, 4, associativity.
- ADDR_WIDTH, 32, byte address width. Line is 64 B (offset = addr[5:0]).
- TAG_WIDTH, ADDR_WIDTH-$clog2(SETS)-6, tag width.
- LRU_BITS, 2, per-way age counter width. Must satisfy 2**LRU_BITS >= WAYS.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- core_req_valid  in  1  core request valid
- core_req_ready  out  1  core request accepted when valid & ready
- core_req_op  in  2  00 LOOKUP, 01 FILL, 10 SET_STATE, 11 reserved
- core_req_addr  in  ADDR_WIDTH  byte address
- core_req_state  in  3  new MOESI state (FILL, SET_STATE)
- snp_req_valid  in  1  snoop SET_STATE request valid
- snp_req_ready  out  1  snoop accepted
- snp_req_addr  in  ADDR_WIDTH  snoop address
- snp_req_state  in  3  new MOESI state
- resp_valid  out  1  response valid; held until resp_ready
- resp_ready  in  1  response consumer ready
- resp_src  out  1  0 core, 1 snoop
- resp_hit  out  1  tag matched a valid way
- resp_way  out  $clog2(WAYS)  hit way, or victim way on FILL miss
- resp_old_state  out  3  prior state of resp_way (I if miss/invalid)
- resp_victim_tag  out  TAG_WIDTH  prior tag of resp_way (for writeback)
- ta_read_set  out  $clog2(SETS)  tag array read set
- ta_read_tags / ta_read_valids / ta_read_states / ta_read_lru  in  per-way vectors  tag array read data (combinational)
- ta_write_en  out  1  tag array write enable
- ta_write_set, ta_write_way, ta_write_tag, ta_write_valid, ta_write_state, ta_write_lru  out  matching widths  tag array write fields
- busy  out  1  FSM not in IDLE

Behaviour:
- Address split: set = addr[6+$clog2(SETS)-1:6]; tag = addr[ADDR_WIDTH-1:ADDR_WIDTH-TAG_WIDTH].
- Reset values: FSM IDLE, all outputs 0. Reset mid-operation drops the pending request, deasserts ta_write_en and resp_valid immediately, and leaves partially written LRU as-is.
- Arbitration (IDLE only): core_req_ready and snp_req_ready are combinational. Snoop has priority: snp_req_ready = IDLE; core_req_ready = IDLE & !snp_req_valid. On accept, latch op/set/tag/state/src.
- FSM states:
  - IDLE -> LOOKUP on accept.
  - LOOKUP: ta_read_set = latched set. Snapshot all ways' tag/valid/state/lru. Compute hit (valid & tag equal, lowest index wins) and victim. Go to UPDATE if writes are needed, else RESP.
  - UPDATE: 1 cycle per written way, then RESP.
  - RESP: resp_valid=1 with fields stable. On resp_ready go to IDLE.
- LRU touch of way k with old age a: way k <- 0; every other valid way with age < a increments; all others unchanged. Miss allocation uses a = WAYS-1. Ages never exceed WAYS-1.
- Victim selection: lowest-index invalid way; else lowest-index way with age == WAYS-1; else way 0.
- LOOKUP op:
  - Hit: WAYS writes (ways 0..WAYS-1 in order, tag/valid/state from snapshot, new lru).
  - Miss: no writes.
- FILL op:
  - Target = hit way if hit (overwrite in place), else victim. Target gets new tag, valid=1, core_req_state. Then LRU touch.
  - WAYS writes.
  - resp_old_state and resp_victim_tag come from the target's snapshot.
- SET_STATE op (core or snoop):
  - Hit: 1 write to the hit way with lru unchanged and state = req state; valid = (state != I). No LRU touch.
  - Miss: no write, resp_hit=0.
- Reserved op: no writes, resp_hit=0.
- Latency accept -> resp_valid:
  - LOOKUP hit / FILL: 2+WAYS cycles.
  - SET_STATE hit: 3 cycles.
  - Miss / no-write: 2 cycles.

Optional Feature:
- Macro CACHE_TAG_CTRL_STATS_EN.
- Defined: adds 32-bit outputs stat_hits, stat_misses and stat_snp_inval, reset to 0 and wrapping at 2**32.
  - stat_hits / stat_misses: increment at RESP entry for core LOOKUP/FILL hits and misses.
  - stat_snp_inval: increments on snoop SET_STATE hits with state I.
- Undefined: ports and counters are absent; all other behaviour identical.

Test Plan:
- FILL addr 0x0000_2040, state E (3'b100), on empty set 1 -> resp_hit=0, resp_way=0, resp_old_state=I; way0 tag=1 valid=1 state=100 lru=0; 6-cycle latency.
- Fill ways 0-3 of set 1 (tags 1..4), then LOOKUP tag 1 -> hit way0; resulting ages way0=0, way1=3, way2=2, way3=1.
- With set 1 full, FILL tag 5 -> victim = way1 (age 3), resp_victim_tag=2; way1 then holds tag 5 with age 0; other valid ways age+1, saturating at 3.
- snp_req_valid and core_req_valid asserted in the same IDLE cycle -> snoop accepted first (resp_src=1), core_req_ready=0 until FSM returns to IDLE.
- Snoop SET_STATE I to tag 5 -> 1 write, valid=0, lru unchanged. A following LOOKUP tag 5 -> resp_hit=0, no ta_write_en.
- Assert rst during UPDATE of way 2 -> ta_write_en and resp_valid drop immediately, busy=0, no response issued; next request is processed normally.
